// File: rtl/div_pkg.sv
// Shared constants and types for the sequential divider.
// Optional signed mode: define SEQ_DIVIDER8_SIGNED_EN.
package div_pkg;
  localparam int DIV_WIDTH = 8;
  localparam int DIV_ITERS = 8;
  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } div_state_t;

  function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] v);
    return v[DIV_WIDTH-1] ? -v : v;
  endfunction
endpackage

// File: rtl/div_trial_sub.sv
// 9-bit trial subtractor: a - b as a + ~b + 1; borrow is the inverted carry-out.
// Purely combinational, no backpressure.
module div_trial_sub (
  input  logic [8:0] a,
  input  logic [8:0] b,
  output logic [8:0] difference,
  output logic       borrow
);
  logic carry;

  assign {carry, difference} = {1'b0, a} + {1'b0, ~b} + 10'd1;
  assign borrow = ~carry;
endmodule

// File: rtl/seq_divider8.sv
// Restoring divider, one quotient bit per cycle; done 9 cycles after start (1 on divide-by-zero,
// 10 with SEQ_DIVIDER8_SIGNED_EN). start is ignored while busy.
module seq_divider8
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  div_state_t       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;
`ifdef SEQ_DIVIDER8_SIGNED_EN
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             fix_q, fix_d;
`endif

  logic [8:0] partial;
  logic [8:0] diff;
  logic       borrow;
  logic       diff_msb_unused;

  // dq_q shifts dividend bits out of the top while quotient bits enter at the bottom
  assign partial = {rem_q, dq_q[WIDTH-1]};

  div_trial_sub u_trial (
    .a          (partial),
    .b          ({1'b0, dsr_q}),
    .difference (diff),
    .borrow     (borrow)
  );

  // After a successful subtract the result is below the divisor, so bit 8 is always clear
  assign diff_msb_unused = diff[8];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dq_d          = dq_q;
    rem_d         = rem_q;
    dsr_d         = dsr_q;
    dz_d          = dz_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
`ifdef SEQ_DIVIDER8_SIGNED_EN
    qneg_d        = qneg_q;
    rneg_d        = rneg_q;
    fix_d         = fix_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          cnt_d  = '0;
          if (divisor == '0) begin
            dq_d    = DIV0_QUOTIENT;
            rem_d   = dividend;
            dsr_d   = '0;
            dz_d    = 1'b1;
            state_d = FINISH;
`ifdef SEQ_DIVIDER8_SIGNED_EN
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            fix_d   = 1'b1;
`endif
          end else begin
            rem_d   = '0;
            dz_d    = 1'b0;
            state_d = RUN;
`ifdef SEQ_DIVIDER8_SIGNED_EN
            dq_d    = abs_val(dividend);
            dsr_d   = abs_val(divisor);
            qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rneg_d  = dividend[WIDTH-1];
            fix_d   = 1'b0;
`else
            dq_d    = dividend;
            dsr_d   = divisor;
`endif
          end
        end
      end

      RUN: begin
        dq_d  = {dq_q[WIDTH-2:0], ~borrow};
        rem_d = borrow ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(DIV_ITERS - 1)) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
`ifdef SEQ_DIVIDER8_SIGNED_EN
        if (!fix_q) begin
          // Extra cycle restores signs on the magnitude results
          fix_d = 1'b1;
          dq_d  = qneg_q ? -dq_q : dq_q;
          rem_d = rneg_q ? -rem_q : rem_q;
        end else begin
`endif
          done_d        = 1'b1;
          busy_d        = 1'b0;
          quotient_d    = dq_q;
          remainder_d   = rem_q;
          div_by_zero_d = dz_q;
          state_d       = IDLE;
`ifdef SEQ_DIVIDER8_SIGNED_EN
        end
`endif
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      dq_q          <= '0;
      rem_q         <= '0;
      dsr_q         <= '0;
      dz_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
`ifdef SEQ_DIVIDER8_SIGNED_EN
      qneg_q        <= 1'b0;
      rneg_q        <= 1'b0;
      fix_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dq_q          <= dq_d;
      rem_q         <= rem_d;
      dsr_q         <= dsr_d;
      dz_q          <= dz_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
`ifdef SEQ_DIVIDER8_SIGNED_EN
      qneg_q        <= qneg_d;
      rneg_q        <= rneg_d;
      fix_q         <= fix_d;
`endif
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;
endmodule

// File: tb/tb_seq_divider8.sv
// Directed bench for seq_divider8; expectations switch with SEQ_DIVIDER8_SIGNED_EN.
module tb_seq_divider8;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = 8'h00;
  logic [7:0] divisor = 8'h00;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  int errors = 0;
  int checks = 0;

`ifdef SEQ_DIVIDER8_SIGNED_EN
  localparam int LAT = 10;
  localparam bit SGN = 1'b1;
`else
  localparam int LAT = 9;
  localparam bit SGN = 1'b0;
`endif

  seq_divider8 #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after a clock edge; returns #1 after the edge that raises done.
  task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input logic edz,
                         input int elat, input int inject_at);
    int lat = 0;
    int busy_cnt = 0;
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = ~a;
    divisor = ~b;
    if (busy) busy_cnt++;
    for (int k = 1; k <= 20; k++) begin
      if (k == inject_at) begin
        start = 1'b1;
        dividend = 8'd10;
        divisor = 8'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    chk({tag, " latency"}, lat, elat);
    chk({tag, " busy cycles"}, busy_cnt, elat);
    chk({tag, " busy at done"}, {31'd0, busy}, 0);
    chk({tag, " quotient"}, {24'd0, quotient}, {24'd0, eq});
    chk({tag, " remainder"}, {24'd0, remainder}, {24'd0, er});
    chk({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, edz});
  endtask

  initial begin
    int done_seen;
    #12;
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset done", {31'd0, done}, 0);
    chk("reset quotient", {24'd0, quotient}, 0);
    chk("reset remainder", {24'd0, remainder}, 0);
    chk("reset dz", {31'd0, div_by_zero}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_div("100/7", 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, LAT, 0);
    @(posedge clk); #1;
    chk("hold done low", {31'd0, done}, 0);
    chk("hold quotient", {24'd0, quotient}, 32'h0E);
    chk("hold remainder", {24'd0, remainder}, 32'h02);

    // Back-to-back issues from here on
    run_div("FF/01", 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, LAT, 0);
    run_div("05/09", 8'h05, 8'h09, 8'h00, 8'h05, 1'b0, LAT, 0);
    run_div("05/00", 8'h05, 8'h00, 8'hFF, 8'h05, 1'b1, 1, 0);
    run_div("10/02", 8'h10, 8'h02, 8'h08, 8'h00, 1'b0, LAT, 0);
    run_div("200/3 inject", 8'd200, 8'd3, SGN ? 8'hEE : 8'h42, SGN ? 8'hFE : 8'h02,
            1'b0, LAT, 4);
    run_div("F9/02", 8'hF9, 8'h02, SGN ? 8'hFD : 8'h7C, SGN ? 8'hFF : 8'h01, 1'b0, LAT, 0);
    run_div("80/FF", 8'h80, 8'hFF, SGN ? 8'h80 : 8'h00, SGN ? 8'h00 : 8'h80, 1'b0, LAT, 0);

    // Reset during RUN
    @(posedge clk); #1;
    start = 1'b1;
    dividend = 8'd200;
    divisor = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst busy", {31'd0, busy}, 0);
    chk("midrst quotient", {24'd0, quotient}, 0);
    chk("midrst remainder", {24'd0, remainder}, 0);
    chk("midrst dz", {31'd0, div_by_zero}, 0);
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) rst_n = 1'b1;
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    chk("midrst no done", done_seen, 0);
    run_div("50/5", 8'd50, 8'd5, 8'h0A, 8'h00, 1'b0, LAT, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
